// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state encoding and counter-width helper shared by serial_adder
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int digit_cnt_w(input int width, input int digit);
    return $clog2(width / digit + 1);
  endfunction
endpackage

// File: rtl/digit_adder.sv
// digit_adder: DIGIT-bit ripple adder of full-adder cells; x,y,ci in -> s,co out
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);
  logic c;
  always_comb begin
    s = '0;
    c = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    co = c;
  end
endmodule

// File: rtl/serial_adder.sv
// serial_adder: digit-serial add/sub; start/sub/a/b/cin in -> busy/done/sum/cout/ovf out
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = digit_cnt_w(WIDTH, DIGIT);
  if (WIDTH < 2 || WIDTH % DIGIT != 0) begin : g_bad_params
    $error("serial_adder: WIDTH must be >= 2 and divisible by DIGIT");
  end
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d, sum_q;
  logic             c_q, cout_q, ovf_q, am_q, bm_q;
  logic [CW-1:0]    cnt_q;
  logic [DIGIT-1:0] ds;
  logic             dc, accept, last;
  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x (a_q[DIGIT-1:0]),
    .y (b_q[DIGIT-1:0]),
    .ci(c_q),
    .s (ds),
    .co(dc)
  );
  always_comb begin
    accept  = start && state_q != RUN;
    last    = state_q == RUN && cnt_q == CW'(N - 1);
    acc_d   = (WIDTH'(ds) << (WIDTH - DIGIT)) | (acc_q >> DIGIT);
    state_d = accept ? RUN : last ? DONE : state_q == DONE ? IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      am_q    <= 1'b0;
      bm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q   <= a;
        b_q   <= sub ? ~b : b;
        c_q   <= sub | cin;
        cnt_q <= '0;
        am_q  <= a[WIDTH-1];
        bm_q  <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
      end else if (state_q == RUN) begin
        a_q   <= a_q >> DIGIT;
        b_q   <= b_q >> DIGIT;
        c_q   <= dc;
        acc_q <= acc_d;
        cnt_q <= cnt_q + CW'(1);
      end
      if (last) begin
        sum_q  <= acc_d;
        cout_q <= dc;
        ovf_q  <= am_q == bm_q && acc_d[WIDTH-1] != am_q;
      end
    end
  end
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard and vector bench for serial_adder at DIGIT 1/2/4/8
module tb_serial_adder;
  typedef struct packed {logic [7:0] sum; logic cout; logic ovf;} res_t;
  typedef struct packed {logic [7:0] a; logic [7:0] b; logic cin; logic sub; res_t r;} vec_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, sub = 1'b0, cin = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic [3:0] busy_w, done_w, cout_w, ovf_w;
  logic [7:0] sum_w [4];
  res_t sb [$];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    serial_adder #(.WIDTH(8), .DIGIT(1 << g)) u_dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
      .busy(busy_w[g]), .done(done_w[g]), .sum(sum_w[g]), .cout(cout_w[g]), .ovf(ovf_w[g])
    );
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  function automatic res_t model(input logic [7:0] x, input logic [7:0] y, input logic ci, input logic s);
    int u, r;
    res_t m;
    u = s ? int'(x) - int'(y) : int'(x) + int'(y) + int'(ci);
    r = s ? int'($signed(x)) - int'($signed(y)) : int'($signed(x)) + int'($signed(y)) + int'(ci);
    m.sum  = 8'(u);
    m.cout = s ? (x >= y) : (u > 255);
    m.ovf  = r > 127 || r < -128;
    return m;
  endfunction
  task automatic monitor();
    res_t e;
    forever begin
      @(negedge clk);
      if (done_w[0]) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_done: done=1 got with no pending op, want none");
        end else begin
          e = sb.pop_front();
          chk("sb_sum", sum_w[0], e.sum);
          chk("sb_cout", cout_w[0], e.cout);
          chk("sb_ovf", ovf_w[0], e.ovf);
        end
      end
    end
  endtask
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic ic, input logic is, input res_t e);
    int n;
    @(negedge clk);
    a = ia; b = ib; cin = ic; sub = is; start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      for (int g = 0; g < 4; g++) begin
        n = 8 >> g;
        chk($sformatf("busy_d%0d_c%0d", 1 << g, k), busy_w[g], k <= n);
        chk($sformatf("done_d%0d_c%0d", 1 << g, k), done_w[g], k == n + 1);
        if (k == n + 1 && g > 0) begin
          chk($sformatf("sum_d%0d", 1 << g), sum_w[g], e.sum);
          chk($sformatf("cout_d%0d", 1 << g), cout_w[g], e.cout);
          chk($sformatf("ovf_d%0d", 1 << g), ovf_w[g], e.ovf);
        end
      end
      if (k < 9) @(negedge clk);
    end
  endtask
  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (!done_w[0] && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
  endtask
  initial begin
    vec_t tbl [8];
    int cyc;
    logic [7:0] ra, rb;
    logic rc, rs;
    tbl[0] = {8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0};
    tbl[1] = {8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = {8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[3] = {8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    tbl[4] = {8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    tbl[5] = {8'h9A, 8'h77, 1'b1, 1'b0, 8'h12, 1'b1, 1'b0};
    tbl[6] = {8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    tbl[7] = {8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_w, 4'h0);
    chk("rst_done", done_w, 4'h0);
    chk("rst_sum", sum_w[0], 8'h00);
    chk("rst_cout", cout_w, 4'h0);
    chk("rst_ovf", ovf_w, 4'h0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, tbl[i].r);
    @(negedge clk);
    a = 8'h3C; b = 8'h0F; cin = 1'b0; sub = 1'b0; start = 1'b1;
    sb.push_back(tbl[0].r);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    a = 8'hAA; b = 8'h55; sub = 1'b1; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(5, cyc);
    chk("ignored_start_latency", cyc, 9);
    repeat (12) @(negedge clk);
    a = 8'h7F; b = 8'h01; cin = 1'b0; sub = 1'b0; start = 1'b1;
    sb.push_back(tbl[2].r);
    @(negedge clk);
    start = 1'b0;
    wait_done(1, cyc);
    chk("b2b_latency1", cyc, 9);
    a = 8'h05; b = 8'h07; sub = 1'b1; start = 1'b1;
    sb.push_back(tbl[3].r);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", busy_w[0], 1'b1);
    wait_done(1, cyc);
    chk("b2b_latency2", cyc, 9);
    @(negedge clk);
    a = 8'hFF; b = 8'h01; cin = 1'b0; sub = 1'b0; start = 1'b1;
    sb.push_back(tbl[1].r);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1; start = 1'b1; a = 8'h3C; b = 8'h0F;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    sb.delete();
    chk("midrst_busy", busy_w, 4'h0);
    chk("midrst_done", done_w, 4'h0);
    chk("midrst_sum", sum_w[0], 8'h00);
    chk("midrst_cout", cout_w[0], 1'b0);
    chk("midrst_ovf", ovf_w[0], 1'b0);
    repeat (12) @(negedge clk);
    chk("midrst_sum_hold", sum_w[0], 8'h00);
    run_op(tbl[5].a, tbl[5].b, tbl[5].cin, tbl[5].sub, tbl[5].r);
    repeat (25) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      run_op(ra, rb, rc, rs, model(ra, rb, rc, rs));
    end
    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
